match_frame_collector: RTL and testbench
========================================

Name: match_frame_collector

Overview:
- Downstream consumer of the serial 1011 sequence detector.
- Takes the detector's per-bit stream (bit value plus match flag) and groups it into fixed-length frames, starting at each frame start strobe.
- Per frame it rebuilds the received byte, a per-position match mask and a match count, then presents them with a valid/ack handshake.
- Keeps a saturating running total of matches for the board display logic.

Parameters:
- FRAME_LEN, 8, bits per frame; also the width of rx_byte and match_mask.
- CNT_W, 4, width of match_cnt; must hold FRAME_LEN.
- TOT_W, 16, width of total_matches.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start strobe (same strobe that loads the upstream detector).
- bit_valid  input  1  bit_in/match_in are valid this cycle.
- bit_in  input  1  current serial bit from the detector.
- match_in  input  1  detector match flag for this bit.
- res_ack  input  1  consumer accepts the held result.
- res_valid  output  1  frame result is valid and held.
- rx_byte  output  FRAME_LEN  received bits, first bit at MSB.
- match_mask  output  FRAME_LEN  match flags, first bit at MSB.
- match_cnt  output  CNT_W  number of matches in the frame.
- total_matches  output  TOT_W  saturating total over all reported frames.
- frame_abort  output  1  one-cycle pulse when an in-progress frame is restarted.
- overrun  output  1  sticky flag: a start was dropped while a result was pending.

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous and active-high. rst has priority over all other inputs on that edge.
- Reset state: IDLE. All outputs are 0. idx and all internal shift registers are 0. A reset mid-frame discards the frame with no report.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - start=1 moves to COLLECT and clears idx, rx_byte, match_mask and match_cnt.
  - bit_valid is ignored.
- COLLECT, on each cycle with bit_valid=1:
  - rx_byte <= {rx_byte[FRAME_LEN-2:0], bit_in}.
  - match_mask <= {match_mask[FRAME_LEN-2:0], match_in}.
  - match_cnt += match_in.
  - idx += 1.
- COLLECT, other rules:
  - bit_valid=0: nothing changes. match_in without bit_valid is ignored.
  - Frame end: at the edge where bit_valid=1 and idx==FRAME_LEN-1, the last bit is absorbed, the state moves to REPORT, and res_valid=1 from the next cycle.
  - At that same edge, total_matches += final match_cnt, saturating at 2^TOT_W-1 with no wrap.
  - Latency: res_valid rises 1 cycle after the final bit_valid.
  - start=1 during COLLECT (any idx): restart the frame by clearing idx, rx_byte, match_mask and match_cnt, and stay in COLLECT. frame_abort pulses high for 1 cycle. The aborted frame is never reported and is not added to the total.
  - If start and bit_valid are high together in COLLECT, start wins and the bit is discarded.
- REPORT:
  - res_valid stays high; rx_byte, match_mask and match_cnt are held stable.
  - bit_valid is ignored.
  - res_ack=1 without start: move to IDLE; res_valid=0 on the next cycle.
  - res_ack=1 with start=1: go directly to COLLECT with fields cleared; res_valid=0 on the next cycle.
  - start=1 without res_ack: the start is dropped, overrun is set, and the state stays in REPORT.
  - overrun is cleared only by rst.
- Widths: match_cnt never exceeds FRAME_LEN. total_matches addition is zero-extended to TOT_W+1 bits, then clamped.

Decomposition:
- Shared package/header seq_pkg:
  - FSM state encoding: IDLE=2'd0, COLLECT=2'd1, REPORT=2'd2.
  - Default FRAME_LEN=8, shared with the upstream detector.
- One sub-module: sat_acc, a parameterised saturating accumulator (width, add input, enable) used for total_matches.

Test Plan:
- Frame 1: rst 2 cycles; start; then 8 bit_valid cycles with bits 1,0,1,1,1,0,1,1 and match_in 0,0,0,1,0,0,0,1 -> 1 cycle after the last bit: res_valid=1, rx_byte=8'hBB, match_mask=8'b0001_0001, match_cnt=2, total_matches=2.
- Frame 2: hold res_ack=0 for 5 cycles, then res_ack=1 -> outputs stable throughout; res_valid=0 next cycle. Then start; bits 0,0,1,1,0,1,1,0 with match only at index 6 -> rx_byte=8'h36, match_mask=8'b0000_0010, match_cnt=1, total_matches=3.
- Gaps in bit_valid: deassert bit_valid for 3 cycles mid-frame, with match_in=1 during the gap -> the gap bits are ignored and the result is identical to the gapless run.
- Abort and reset mid-frame: start again after 4 bits -> frame_abort pulses 1 cycle, next 8 bits form a clean frame, total excludes the aborted bits. rst after 5 bits of a frame -> all outputs 0, FSM in IDLE, no res_valid.
- Overrun and back-to-back: start while in REPORT with res_ack=0 -> overrun=1 and stays 1, result unchanged. res_ack and start on the same edge -> res_valid=0 next cycle and a new frame collects immediately.
- Saturation: TOT_W=4; feed 2 frames of 8 matches each (match_in=1 on every bit) -> total_matches=8, then 15 (clamped, no wrap).

Source files
------------

// File: rtl/seq_pkg.sv
// Definitions shared by the 1011 detector and the frame collector:
// the FSM state encoding and the default frame length.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam int DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator: adds a narrower unsigned value on enable and
// clamps at all-ones instead of wrapping.
module sat_acc #(
   parameter int W     = 16,
   parameter int ADD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [ADD_W-1:0] add,
   output logic [W-1:0]     acc
);

   // One guard bit catches the carry-out that signals saturation.
   logic [W:0] sum;
   assign sum = {1'b0, acc} + {{(W + 1 - ADD_W){1'b0}}, add};

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (en)
         acc <= sum[W] ? {W{1'b1}} : sum[W-1:0];
   end

endmodule

// File: rtl/match_frame_collector.sv
// Groups the detector's per-bit stream into fixed-length frames and reports
// received byte, match mask and match count through a valid/ack handshake.
module match_frame_collector
   import seq_pkg::*;
#(
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
   parameter int CNT_W     = 4,
   parameter int TOT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bit_valid,
   input  logic                 bit_in,
   input  logic                 match_in,
   input  logic                 res_ack,
   output logic                 res_valid,
   output logic [FRAME_LEN-1:0] rx_byte,
   output logic [FRAME_LEN-1:0] match_mask,
   output logic [CNT_W-1:0]     match_cnt,
   output logic [TOT_W-1:0]     total_matches,
   output logic                 frame_abort,
   output logic                 overrun
);

   localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [FRAME_LEN-1:0] rx_reg, rx_next;
   logic [FRAME_LEN-1:0] mask_reg, mask_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic                 abort_reg, abort_next;
   logic                 overrun_reg, overrun_next;
   logic                 acc_en;
   logic [CNT_W-1:0]     final_cnt;

   // The last bit's match must be included in the total, so add the
   // count as it will be after this edge, not the registered one.
   assign final_cnt = cnt_reg + CNT_W'(match_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         rx_reg      <= '0;
         mask_reg    <= '0;
         cnt_reg     <= '0;
         abort_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         rx_reg      <= rx_next;
         mask_reg    <= mask_next;
         cnt_reg     <= cnt_next;
         abort_reg   <= abort_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      rx_next      = rx_reg;
      mask_next    = mask_reg;
      cnt_next     = cnt_reg;
      abort_next   = 1'b0;
      overrun_next = overrun_reg;
      acc_en       = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = COLLECT;
               idx_next   = '0;
               rx_next    = '0;
               mask_next  = '0;
               cnt_next   = '0;
            end
         end
         COLLECT: begin
            if (start) begin
               idx_next   = '0;
               rx_next    = '0;
               mask_next  = '0;
               cnt_next   = '0;
               abort_next = 1'b1;
            end else if (bit_valid) begin
               rx_next   = {rx_reg[FRAME_LEN-2:0], bit_in};
               mask_next = {mask_reg[FRAME_LEN-2:0], match_in};
               cnt_next  = final_cnt;
               idx_next  = idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  state_next = REPORT;
                  idx_next   = '0;
                  acc_en     = 1'b1;
               end
            end
         end
         REPORT: begin
            if (res_ack) begin
               if (start) begin
                  state_next = COLLECT;
                  idx_next   = '0;
                  rx_next    = '0;
                  mask_next  = '0;
                  cnt_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end else if (start) begin
               overrun_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   sat_acc #(
      .W     (TOT_W),
      .ADD_W (CNT_W)
   ) u_total (
      .clk (clk),
      .rst (rst),
      .en  (acc_en),
      .add (final_cnt),
      .acc (total_matches)
   );

   assign res_valid   = (state_reg == REPORT);
   assign rx_byte     = rx_reg;
   assign match_mask  = mask_reg;
   assign match_cnt   = cnt_reg;
   assign frame_abort = abort_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_match_frame_collector.sv
// Directed bench for match_frame_collector; a 16-bit and a 4-bit-total
// instance share stimulus and are checked against a frame-level model.
module tb_match_frame_collector;

   logic clk = 1'b0;
   logic rst, start, bit_valid, bit_in, match_in, res_ack;

   logic       d_valid, d_abort, d_overrun;
   logic [7:0] d_rx, d_mask;
   logic [3:0] d_cnt;
   logic [15:0] d_total;

   logic       s_valid, s_abort, s_overrun;
   logic [7:0] s_rx, s_mask;
   logic [3:0] s_cnt;
   logic [3:0] s_total;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   match_frame_collector dut (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
      .bit_in(bit_in), .match_in(match_in), .res_ack(res_ack),
      .res_valid(d_valid), .rx_byte(d_rx), .match_mask(d_mask),
      .match_cnt(d_cnt), .total_matches(d_total),
      .frame_abort(d_abort), .overrun(d_overrun)
   );

   match_frame_collector #(.TOT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
      .bit_in(bit_in), .match_in(match_in), .res_ack(res_ack),
      .res_valid(s_valid), .rx_byte(s_rx), .match_mask(s_mask),
      .match_cnt(s_cnt), .total_matches(s_total),
      .frame_abort(s_abort), .overrun(s_overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a queue of accepted bits, a pending result and an
   // unbounded running total that each instance clamps to its own width.
   logic q_bits[$];
   logic q_match[$];
   bit   m_init = 0, m_collecting, m_valid, m_fresh, m_abort, m_overrun;
   int   m_rx, m_mask, m_cnt, m_total;

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1; m_collecting = 0; m_valid = 0; m_fresh = 1;
         m_abort = 0; m_overrun = 0;
         m_rx = 0; m_mask = 0; m_cnt = 0; m_total = 0;
         q_bits.delete(); q_match.delete();
      end else begin
         m_abort = 0;
         if (m_valid) begin
            if (res_ack) begin
               m_valid = 0;
               if (start) begin
                  m_collecting = 1; q_bits.delete(); q_match.delete();
               end
            end else if (start) begin
               m_overrun = 1;
            end
         end else if (m_collecting) begin
            if (start) begin
               m_abort = 1; q_bits.delete(); q_match.delete();
            end else if (bit_valid) begin
               q_bits.push_back(bit_in);
               q_match.push_back(match_in);
               if (q_bits.size() == 8) begin
                  m_rx = 0; m_mask = 0; m_cnt = 0;
                  for (int i = 0; i < 8; i++) begin
                     m_rx   += int'(q_bits[i]) << (7 - i);
                     m_mask += int'(q_match[i]) << (7 - i);
                     m_cnt  += int'(q_match[i]);
                  end
                  m_total += m_cnt;
                  m_valid = 1; m_collecting = 0;
               end
            end
         end else if (start) begin
            m_collecting = 1; m_fresh = 0;
            q_bits.delete(); q_match.delete();
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("res_valid", 32'(d_valid), 32'(m_valid));
         chk("sat.res_valid", 32'(s_valid), 32'(m_valid));
         chk("frame_abort", 32'(d_abort), 32'(m_abort));
         chk("sat.frame_abort", 32'(s_abort), 32'(m_abort));
         chk("overrun", 32'(d_overrun), 32'(m_overrun));
         chk("sat.overrun", 32'(s_overrun), 32'(m_overrun));
         chk("total", 32'(d_total), (m_total > 65535) ? 32'd65535 : 32'(m_total));
         chk("sat.total", 32'(s_total), (m_total > 15) ? 32'd15 : 32'(m_total));
         if (m_valid || m_fresh) begin
            chk("rx_byte", 32'(d_rx), 32'(m_rx));
            chk("match_mask", 32'(d_mask), 32'(m_mask));
            chk("match_cnt", 32'(d_cnt), 32'(m_cnt));
            chk("sat.rx_byte", 32'(s_rx), 32'(m_rx));
            chk("sat.match_cnt", 32'(s_cnt), 32'(m_cnt));
         end
      end
   end

   task automatic drive(input logic s, input logic bv, input logic b, input logic m, input logic a);
      start = s; bit_valid = bv; bit_in = b; match_in = m; res_ack = a;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] bits, input logic [7:0] m);
      for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, bits[i], m[i], 1'b0);
   endtask

   task automatic lit_result(input string tag, input logic [7:0] rx, input logic [7:0] mask,
                             input logic [3:0] cnt, input logic [15:0] tot);
      $display("frame %s: rx=%02h mask=%02h cnt=%0d total=%0d", tag, d_rx, d_mask, d_cnt, d_total);
      chk({tag, ".valid"}, 32'(d_valid), 32'd1);
      chk({tag, ".rx"}, 32'(d_rx), 32'(rx));
      chk({tag, ".mask"}, 32'(d_mask), 32'(mask));
      chk({tag, ".cnt"}, 32'(d_cnt), 32'(cnt));
      chk({tag, ".total"}, 32'(d_total), 32'(tot));
   endtask

   initial begin
      rst = 1'b1; start = 0; bit_valid = 0; bit_in = 0; match_in = 0; res_ack = 0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("reset.valid", 32'(d_valid), 32'd0);
      chk("reset.total", 32'(d_total), 32'd0);

      // Frame 1, then hold the result for 5 cycles before acking
      drive(1, 0, 0, 0, 0);
      send_frame(8'hBB, 8'h11);
      lit_result("f1", 8'hBB, 8'h11, 4'd2, 16'd2);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 1, 1, 0);
         chk("f1.hold_rx", 32'(d_rx), 32'hBB);
      end
      drive(0, 0, 0, 0, 1);
      chk("f1.ack_valid", 32'(d_valid), 32'd0);

      // Frame 2
      drive(1, 0, 0, 0, 0);
      send_frame(8'h36, 8'h02);
      lit_result("f2", 8'h36, 8'h02, 4'd1, 16'd3);
      drive(0, 0, 0, 0, 1);

      // Gap of 3 invalid cycles with match_in high after the third bit
      drive(1, 0, 0, 0, 0);
      for (int i = 7; i >= 0; i--) begin
         if (i == 4) for (int g = 0; g < 3; g++) drive(0, 0, 1, 1, 0);
         drive(0, 1, 1'((8'hBB >> i) & 8'h01), 1'((8'h11 >> i) & 8'h01), 0);
      end
      lit_result("gap", 8'hBB, 8'h11, 4'd2, 16'd5);
      drive(0, 0, 0, 0, 1);

      // Restart after 4 bits
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 0);
      drive(1, 0, 0, 0, 0);
      chk("abort.pulse", 32'(d_abort), 32'd1);
      send_frame(8'h36, 8'h02);
      lit_result("abort", 8'h36, 8'h02, 4'd1, 16'd6);
      drive(0, 0, 0, 0, 1);

      // Reset after 5 bits of a frame
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 1, 1, 0);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("midrst.rx", 32'(d_rx), 32'd0);
      chk("midrst.cnt", 32'(d_cnt), 32'd0);
      chk("midrst.total", 32'(d_total), 32'd0);
      drive(0, 1, 1, 1, 0);
      chk("midrst.valid", 32'(d_valid), 32'd0);

      // Overrun, then ack and start on the same edge
      drive(1, 0, 0, 0, 0);
      send_frame(8'hBB, 8'h11);
      drive(1, 0, 0, 0, 0);
      chk("ovr.flag", 32'(d_overrun), 32'd1);
      drive(0, 0, 0, 0, 0);
      lit_result("ovr", 8'hBB, 8'h11, 4'd2, 16'd2);
      drive(1, 0, 0, 0, 1);
      chk("b2b.valid", 32'(d_valid), 32'd0);
      send_frame(8'h36, 8'h02);
      lit_result("b2b", 8'h36, 8'h02, 4'd1, 16'd3);
      chk("ovr.sticky", 32'(d_overrun), 32'd1);
      drive(0, 0, 0, 0, 1);

      // Saturation on the 4-bit total instance
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(1, 0, 0, 0, 0);
      send_frame(8'hFF, 8'hFF);
      chk("sat1.total", 32'(s_total), 32'd8);
      drive(1, 0, 0, 0, 1);
      send_frame(8'hFF, 8'hFF);
      chk("sat2.total", 32'(s_total), 32'd15);
      chk("sat2.wide_total", 32'(d_total), 32'd16);
      chk("sat2.cnt", 32'(s_cnt), 32'd8);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
